// File: rtl/adder_share_arbiter_if.sv
// Bundle for adder_share_arbiter: requester operand handshake, adder
// operand/result wires, response handshake and busy status.
//   slave  : view taken by the arbiter (drives req_ready, add_*, rsp_*, busy)
//   master : view taken by the surrounding logic (requesters, adder, consumer)
interface adder_share_arbiter_if #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ID_W    = 2
);
  localparam int unsigned DATA_W = 32;

  // requester side
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W*NUM_REQ-1:0] req_a;
  logic [DATA_W*NUM_REQ-1:0] req_b;
  logic [NUM_REQ-1:0]        req_cin;

  // shared ripple adder
  logic [DATA_W-1:0]         add_a;
  logic [DATA_W-1:0]         add_b;
  logic                      add_cin;
  logic [DATA_W-1:0]         add_sum;
  logic                      add_cout;
  logic                      add_ovf;

  // response side
  logic                      rsp_valid;
  logic                      rsp_ready;
  logic [ID_W-1:0]           rsp_id;
  logic [DATA_W-1:0]         rsp_sum;
  logic                      rsp_cout;
  logic                      rsp_ovf;

  logic                      busy;

  modport slave (
    input  req_valid, req_a, req_b, req_cin,
    input  add_sum, add_cout, add_ovf,
    input  rsp_ready,
    output req_ready,
    output add_a, add_b, add_cin,
    output rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
    output busy
  );

  modport master (
    output req_valid, req_a, req_b, req_cin,
    output add_sum, add_cout, add_ovf,
    output rsp_ready,
    input  req_ready,
    input  add_a, add_b, add_cin,
    input  rsp_valid, rsp_id, rsp_sum, rsp_cout, rsp_ovf,
    input  busy
  );
endinterface

// File: rtl/adder_share_arbiter.sv
// adder_share_arbiter: time-shares one multi-cycle ripple-carry adder among
// NUM_REQ requesters. Round-robin grant in IDLE, operands latched into the
// adder-facing registers and held while the ripple settles for SETTLE_CYCLES,
// result captured with the owner's ID and held until the consumer accepts.
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous active-low reset; aborts any operation in flight
//   bus      adder_share_arbiter_if.slave
//            req_valid/req_ready/req_a/req_b/req_cin : per-requester handshake
//            add_a/add_b/add_cin -> adder, add_sum/add_cout/add_ovf <- adder
//            rsp_valid/rsp_ready/rsp_id/rsp_sum/rsp_cout/rsp_ovf : result
//            busy : high while an operation is settling or awaiting pickup
module adder_share_arbiter #(
  parameter int unsigned NUM_REQ       = 4,
  parameter int unsigned SETTLE_CYCLES = 8,
  parameter int unsigned ID_W          = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  adder_share_arbiter_if.slave bus
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned CNT_W  = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NUM_REQ - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETTLE = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ID_W-1:0]     rr_q, rr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ID_W-1:0]     gid_q, gid_d;
  logic [DATA_W-1:0]   add_a_q, add_a_d;
  logic [DATA_W-1:0]   add_b_q, add_b_d;
  logic                add_cin_q, add_cin_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0]   rsp_sum_q, rsp_sum_d;
  logic                rsp_cout_q, rsp_cout_d;
  logic                rsp_ovf_q, rsp_ovf_d;
  logic                busy_q, busy_d;

  logic                grant_vld;
  logic [ID_W-1:0]     grant_idx;
  logic [ID_W-1:0]     cand;
  logic [DATA_W-1:0]   sel_a;
  logic [DATA_W-1:0]   sel_b;
  logic                sel_cin;
  logic [NUM_REQ-1:0]  req_ready_c;

  // Round-robin search: first valid requester starting at rr_q, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_W'((32'(rr_q) + k) % NUM_REQ);
      if (!grant_vld && bus.req_valid[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  // Operand mux for the current winner.
  always_comb begin
    sel_a   = '0;
    sel_b   = '0;
    sel_cin = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == grant_idx) begin
        sel_a   = bus.req_a[DATA_W*i +: DATA_W];
        sel_b   = bus.req_b[DATA_W*i +: DATA_W];
        sel_cin = bus.req_cin[i];
      end
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    gid_d       = gid_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    add_cin_d   = add_cin_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_cout_d  = rsp_cout_q;
    rsp_ovf_d   = rsp_ovf_q;
    req_ready_c = '0;

    unique case (state_q)
      S_IDLE: begin
        if (grant_vld) begin
          req_ready_c[grant_idx] = 1'b1;
          add_a_d   = sel_a;
          add_b_d   = sel_b;
          add_cin_d = sel_cin;
          gid_d     = grant_idx;
          cnt_d     = CNT_INIT;
          state_d   = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // add_* stay untouched so the ripple sees constant operands.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          rsp_sum_d   = bus.add_sum;
          rsp_cout_d  = bus.add_cout;
          rsp_ovf_d   = bus.add_ovf;
          rsp_id_d    = gid_q;
          rsp_valid_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          rsp_valid_d = 1'b0;
          // Pointer moves only on completion, to the requester after the owner.
          rr_d        = (gid_q == LAST_ID) ? '0 : gid_q + ID_W'(1);
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      rr_q        <= '0;
      cnt_q       <= '0;
      gid_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      add_cin_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      gid_q       <= gid_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      add_cin_q   <= add_cin_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_cout_q  <= rsp_cout_d;
      rsp_ovf_q   <= rsp_ovf_d;
      busy_q      <= busy_d;
    end
  end

  // Grant is combinational; masked during reset so every output reads zero.
  assign bus.req_ready = reset_n ? req_ready_c : '0;
  assign bus.add_a     = add_a_q;
  assign bus.add_b     = add_b_q;
  assign bus.add_cin   = add_cin_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_sum   = rsp_sum_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Self-checking bench for adder_share_arbiter: directed scenarios plus
// randomized operations checked against a plain-arithmetic reference.
module tb_adder_share_arbiter;

  localparam int N      = 4;
  localparam int SETTLE = 8;
  localparam int IDW    = 2;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic clk;
  logic reset_n;
  int   n_tests;
  int   n_fail;
  int   mptr;

  adder_share_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus ();

  adder_share_arbiter #(
    .NUM_REQ      (N),
    .SETTLE_CYCLES(SETTLE),
    .ID_W         (IDW)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  // Stand-in for the shared 32-bit adder.
  logic [32:0] add_full;
  assign add_full     = {1'b0, bus.add_a} + {1'b0, bus.add_b} + {32'd0, bus.add_cin};
  assign bus.add_sum  = add_full[31:0];
  assign bus.add_cout = add_full[32];
  assign bus.add_ovf  = (bus.add_a[31] == bus.add_b[31]) && (add_full[31] != bus.add_a[31]);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", n_tests);
    $fatal(1, "watchdog");
  end

  // Reference result {ovf, cout, sum} from integer arithmetic.
  function automatic logic [33:0] model_add(input logic [31:0] a, input logic [31:0] b,
                                            input logic cin);
    longint u, s;
    logic [31:0] sum;
    logic cout, ovf;
    u    = longint'(a) + longint'(b) + longint'(cin);
    sum  = u[31:0];
    cout = (u >= 64'sh1_0000_0000);
    s    = longint'($signed(a)) + longint'($signed(b)) + longint'(cin);
    ovf  = (s > SMAX) || (s < SMIN);
    return {ovf, cout, sum};
  endfunction

  function automatic int rr_winner(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      if (v[IDW'((ptr + k) % N)]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] oh(input int r);
    logic [N-1:0] v;
    v = '0;
    if (r >= 0) v[IDW'(r)] = 1'b1;
    return v;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_ops(input int r, input logic [31:0] a, input logic [31:0] b,
                         input logic cin);
    bus.req_a[r*32 +: 32] = a;
    bus.req_b[r*32 +: 32] = b;
    bus.req_cin[IDW'(r)]  = cin;
  endtask

  task automatic check_zero(input string t);
    check({t, "_ready"}, 64'(bus.req_ready), 0);
    check({t, "_add_a"}, 64'(bus.add_a), 0);
    check({t, "_add_b"}, 64'(bus.add_b), 0);
    check({t, "_add_cin"}, 64'(bus.add_cin), 0);
    check({t, "_rsp_valid"}, 64'(bus.rsp_valid), 0);
    check({t, "_rsp_id"}, 64'(bus.rsp_id), 0);
    check({t, "_rsp_sum"}, 64'(bus.rsp_sum), 0);
    check({t, "_cout_ovf_busy"}, 64'({bus.rsp_cout, bus.rsp_ovf, bus.busy}), 0);
  endtask

  // Called and returns at 1 time unit after a rising edge.
  task automatic apply_reset(input string t);
    #3;
    reset_n = 1'b0;
    #1;
    check_zero(t);
    bus.req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    mptr = 0;
    @(posedge clk);
    #1;
  endtask

  // One complete operation for requester r (only r valid at issue). After the
  // accept, bg drives the other valids to prove no grant happens while busy.
  task automatic run_op(input string t, input int r, input logic [31:0] a,
                        input logic [31:0] b, input logic cin, input int hold,
                        input logic [N-1:0] bg);
    logic [33:0] exp;
    int k;
    exp = model_add(a, b, cin);
    set_ops(r, a, b, cin);
    bus.req_valid = oh(r);
    #1;
    k = 0;
    while (bus.req_ready == '0 && k < 20) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({t, "_grant"}, 64'(bus.req_ready), 64'(oh(r)));
    if (bus.req_ready == '0) begin
      bus.req_valid = '0;
      return;
    end
    @(posedge clk);
    #1;
    bus.req_valid = bg;
    set_ops(r, $urandom, $urandom, 1'($urandom_range(0, 1)));
    check({t, "_add_a"}, 64'(bus.add_a), 64'(a));
    check({t, "_add_b"}, 64'(bus.add_b), 64'(b));
    check({t, "_add_cin"}, 64'(bus.add_cin), 64'(cin));
    check({t, "_busy"}, 64'(bus.busy), 1);
    for (int i = 1; i < SETTLE; i++) begin
      @(posedge clk);
      #1;
      check({t, "_early_rsp"}, 64'({bus.rsp_valid, bus.req_ready}), 0);
    end
    @(posedge clk);
    #1;
    check({t, "_rsp_valid"}, 64'(bus.rsp_valid), 1);
    check({t, "_rsp_id"}, 64'(bus.rsp_id), 64'(r));
    check({t, "_rsp_sum"}, 64'(bus.rsp_sum), 64'(exp[31:0]));
    check({t, "_rsp_cout"}, 64'(bus.rsp_cout), 64'(exp[32]));
    check({t, "_rsp_ovf"}, 64'(bus.rsp_ovf), 64'(exp[33]));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({t, "_hold"}, {bus.rsp_valid, bus.busy, bus.add_a, bus.rsp_sum[29:0]},
            {1'b1, 1'b1, a, exp[29:0]});
      check({t, "_hold_noready"}, 64'(bus.req_ready), 0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.rsp_ready = 1'b0;
    check({t, "_done"}, 64'({bus.rsp_valid, bus.busy}), 0);
    mptr = (r + 1) % N;
    if (bg != '0) begin
      check({t, "_next_grant"}, 64'(bus.req_ready), 64'(oh(rr_winner(bg, mptr))));
    end
    bus.req_valid = '0;
  endtask

  initial begin
    int ngr, nrsp, p_id, p_cyc, last_g, nr, w;
    logic [31:0] p_a, p_b;
    logic p_cin;
    logic [33:0] exp;
    logic [N-1:0] prev_ready;
    logic seen_ready;

    n_tests = 0;
    n_fail  = 0;
    mptr    = 0;
    reset_n = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    bus.rsp_ready = 1'b0;
    #2;
    bus.req_valid = '1;
    #1;
    check_zero("reset");
    bus.req_valid = '0;
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // single operation, exact latency
    run_op("t1", 0, 32'd50, 32'd29975, 1'b1, 0, '0);

    // signed overflow and unsigned wrap
    run_op("t3_ovf", 2, 32'h7FFF_FFFF, 32'd1, 1'b0, 0, '0);
    run_op("t3_wrap", 1, 32'hFFFF_FFFF, 32'd1, 1'b0, 0, '0);

    // backpressure for 20 cycles with other requesters waiting
    run_op("t4", 3, $urandom, $urandom, 1'($urandom_range(0, 1)), 20, 4'b0011);

    // fairness with all requesters valid and consumer always ready
    apply_reset("t2_rst");
    bus.rsp_ready = 1'b1;
    bus.req_valid = '1;
    ngr = 0; nrsp = 0; last_g = -1; prev_ready = '0;
    p_id = 0; p_cyc = 0; p_a = '0; p_b = '0; p_cin = 1'b0;
    for (int cyc = 0; cyc < 200 && nrsp < 6; cyc++) begin
      for (int i = 0; i < N; i++) set_ops(i, $urandom, $urandom, 1'($urandom_range(0, 1)));
      #1;
      if (bus.req_ready != '0) begin
        w = rr_winner('1, mptr);
        check("t2_grant", 64'(bus.req_ready), 64'(oh(w)));
        check("t2_order", 64'(bus.req_ready), 64'(oh(ngr % N)));
        check("t2_pulse", 64'(prev_ready), 0);
        if (last_g >= 0) check("t2_spacing", 64'(cyc - last_g), 64'(SETTLE + 2));
        last_g = cyc;
        p_id   = w;
        p_cyc  = cyc;
        p_a    = bus.req_a[w*32 +: 32];
        p_b    = bus.req_b[w*32 +: 32];
        p_cin  = bus.req_cin[IDW'(w)];
        ngr++;
      end
      if (bus.rsp_valid) begin
        exp = model_add(p_a, p_b, p_cin);
        check("t2_id", 64'(bus.rsp_id), 64'(p_id));
        check("t2_sum", 64'({bus.rsp_ovf, bus.rsp_cout, bus.rsp_sum}), 64'(exp));
        check("t2_latency", 64'(cyc - p_cyc), 64'(SETTLE + 1));
        mptr = (p_id + 1) % N;
        nrsp++;
      end
      prev_ready = bus.req_ready;
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b0;
    check("t2_count", 64'(nrsp), 6);

    // randomized operations with random backpressure and waiting requesters
    for (int it = 0; it < 8; it++) begin
      run_op("rnd", $urandom_range(0, N - 1), $urandom, $urandom,
             1'($urandom_range(0, 1)), $urandom_range(0, 3), N'($urandom));
    end

    // reset in the middle of SETTLE
    set_ops(1, $urandom, $urandom, 1'b1);
    bus.req_valid = 4'b0010;
    #1;
    check("t5_grant", 64'(bus.req_ready), 64'(4'b0010));
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    repeat (3) @(posedge clk);
    #1;
    bus.req_valid = '1;
    apply_reset("t5_rst");
    for (int i = 0; i < SETTLE + 4; i++) begin
      check("t5_no_stale", 64'({bus.rsp_valid, bus.busy}), 0);
      @(posedge clk);
      #1;
    end
    bus.req_valid = 4'b1001;
    #1;
    check("t5_ptr0", 64'(bus.req_ready), 64'(4'b0001));
    bus.req_valid = '0;
    run_op("t5_op", 0, $urandom, $urandom, 1'($urandom_range(0, 1)), 1, '0);

    // requester 1 drops valid after losing arbitration
    run_op("t6_pre", 3, $urandom, $urandom, 1'b0, 0, '0);
    p_a = $urandom;
    p_b = $urandom;
    set_ops(0, p_a, p_b, 1'b1);
    bus.req_valid = 4'b0011;
    #1;
    check("t6_grant", 64'(bus.req_ready), 64'(4'b0001));
    @(posedge clk);
    #1;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    nr = 0;
    seen_ready = 1'b0;
    exp = model_add(p_a, p_b, 1'b1);
    for (int i = 0; i < 30; i++) begin
      if (bus.req_ready != '0) seen_ready = 1'b1;
      if (bus.rsp_valid) begin
        nr++;
        check("t6_id", 64'(bus.rsp_id), 0);
        check("t6_sum", 64'({bus.rsp_ovf, bus.rsp_cout, bus.rsp_sum}), 64'(exp));
      end
      @(posedge clk);
      #1;
    end
    bus.rsp_ready = 1'b0;
    check("t6_one_rsp", 64'(nr), 1);
    check("t6_no_grant", 64'(seen_ready), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
